// File: rtl/bin_decimal_display.sv
// Iterative binary-to-BCD converter (shift-and-add-3, one bit per clock) driving
// DIGITS seven-segment displays with leading-zero blanking and overflow dashes.

module bin_decimal_display_seg #(
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);
    logic [6:0] pat;

    always_comb begin
        pat = 7'h00;
        case (digit)
            4'd0: pat = 7'h3F;
            4'd1: pat = 7'h06;
            4'd2: pat = 7'h5B;
            4'd3: pat = 7'h4F;
            4'd4: pat = 7'h66;
            4'd5: pat = 7'h6D;
            4'd6: pat = 7'h7D;
            4'd7: pat = 7'h07;
            4'd8: pat = 7'h7F;
            4'd9: pat = 7'h6F;
            default: pat = 7'h00;
        endcase
        // Overflow dash wins over blanking.
        if (dash)
            pat = 7'h40;
        else if (blank)
            pat = 7'h00;
        seg = (SEG_ACTIVE_LOW != 0) ? ~pat : pat;
    end
endmodule

module bin_decimal_display #(
    parameter int BIN_WIDTH      = 20,
    parameter int DIGITS         = 6,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    input  logic [BIN_WIDTH-1:0]   i_bin,
    input  logic                   i_lzb,
    output logic                   o_ready,
    output logic                   o_done,
    output logic [4*DIGITS-1:0]    o_bcd,
    output logic [7*DIGITS-1:0]    o_seg,
    output logic                   o_overflow
);
    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_WIDTH);
    localparam logic [7*DIGITS-1:0] SEG_BLANK = {(7*DIGITS){SEG_ACTIVE_LOW != 0}};

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t               state_q, state_d;
    logic [BIN_WIDTH-1:0] shift_q;
    logic [SW-1:0]        scratch_q;
    logic [SW-1:0]        adj;
    logic [CW-1:0]        cnt_q;
    logic                 ovf_q;
    logic                 lzb_q;
    logic [DIGITS-1:0]    blank;
    logic                 zero_run;
    logic [7*DIGITS-1:0]  seg_nxt;

    // Per-digit add-3 correction and segment encoding.
    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        assign adj[4*d +: 4] = (scratch_q[4*d +: 4] >= 4'd5) ? scratch_q[4*d +: 4] + 4'd3
                                                             : scratch_q[4*d +: 4];
        bin_decimal_display_seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg (
            .digit (scratch_q[4*d +: 4]),
            .blank (blank[d]),
            .dash  (ovf_q),
            .seg   (seg_nxt[7*d +: 7])
        );
    end

    // A digit blanks only while every digit above it is also zero; digit 0 always shows.
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            zero_run = zero_run && (scratch_q[4*d +: 4] == 4'd0);
            blank[d] = lzb_q && zero_run && (d != 0);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_valid) state_d = SHIFT;
            SHIFT:   if (cnt_q == CW'(BIN_WIDTH - 1)) state_d = LATCH;
            LATCH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_ready = (state_q == IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            lzb_q      <= 1'b0;
            o_done     <= 1'b0;
            o_bcd      <= '0;
            o_seg      <= SEG_BLANK;
            o_overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            o_done  <= 1'b0;
            case (state_q)
                IDLE: if (i_valid) begin
                    shift_q   <= i_bin;
                    scratch_q <= '0;
                    cnt_q     <= '0;
                    ovf_q     <= 1'b0;
                    lzb_q     <= i_lzb;
                end
                SHIFT: begin
                    // A set bit 3 in the corrected top digit would be shifted out.
                    if (adj[SW-1]) ovf_q <= 1'b1;
                    scratch_q <= {adj[SW-2:0], shift_q[BIN_WIDTH-1]};
                    shift_q   <= {shift_q[BIN_WIDTH-2:0], 1'b0};
                    cnt_q     <= cnt_q + 1'b1;
                end
                LATCH: begin
                    o_bcd      <= scratch_q;
                    o_overflow <= ovf_q;
                    o_seg      <= seg_nxt;
                    o_done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bin_decimal_display.sv
// Bench for bin_decimal_display: directed and random values against a decimal
// arithmetic reference model, on a default and a small active-high instance.

module tb_bin_decimal_display;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        va, lza, ra, da, ova;
    logic [19:0] ba;
    logic [23:0] bcda;
    logic [41:0] sega;
    logic        vb, lzbb, rb, db, ovb;
    logic [7:0]  bb;
    logic [15:0] bcdb;
    logic [27:0] segb;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bin_decimal_display u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(va), .i_bin(ba), .i_lzb(lza),
        .o_ready(ra), .o_done(da), .o_bcd(bcda), .o_seg(sega), .o_overflow(ova)
    );

    bin_decimal_display #(.BIN_WIDTH(8), .DIGITS(4), .SEG_ACTIVE_LOW(0)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vb), .i_bin(bb), .i_lzb(lzbb),
        .o_ready(rb), .o_done(db), .o_bcd(bcdb), .o_seg(segb), .o_overflow(ovb)
    );

    function automatic longint p10(int n);
        longint r = 1;
        repeat (n) r *= 10;
        return r;
    endfunction

    function automatic logic [63:0] m_bcd(longint v, int nd);
        logic [63:0] r = '0;
        longint x = v % p10(nd);
        for (int d = 0; d < nd; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [63:0] m_seg(longint v, int nd, bit lzb, bit al);
        logic [6:0]  tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        logic [63:0] r  = '0;
        logic [63:0] b  = m_bcd(v, nd);
        bit          ov = (v >= p10(nd));
        int          hi = 0;
        logic [6:0]  p;
        for (int d = 0; d < nd; d++)
            if (b[4*d +: 4] != 4'd0) hi = d;
        for (int d = 0; d < nd; d++) begin
            if (ov)                 p = 7'h40;
            else if (lzb && d > hi) p = 7'h00;
            else                    p = tbl[b[4*d +: 4]];
            r[7*d +: 7] = al ? ~p : p;
        end
        return r;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_a(longint v, bit lz, bit poke);
        int cyc  = 0;
        int lows = 0;
        va = 1'b1; ba = 20'(v); lza = lz;
        @(posedge clk); #1;
        va = 1'b0; ba = 20'($urandom); lza = ~lz;
        if (!ra) lows++;
        while (cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (poke && cyc == 5) begin va = 1'b1; ba = 20'd7; end
            if (poke && cyc == 6) va = 1'b0;
            if (da) break;
            if (!ra) lows++;
        end
        check("a_latency", 64'(cyc), 64'd21);
        check("a_ready_low", 64'(lows), 64'd21);
        check("a_ready_back", 64'(ra), 64'd1);
        check("a_bcd", 64'(bcda), m_bcd(v, 6));
        check("a_seg", 64'(sega), m_seg(v, 6, lz, 1'b1));
        check("a_ovf", 64'(ova), 64'(v >= 64'd1000000));
    endtask

    task automatic run_b(longint v, bit lz);
        int cyc = 0;
        vb = 1'b1; bb = 8'(v); lzbb = lz;
        @(posedge clk); #1;
        vb = 1'b0; bb = 8'($urandom);
        while (cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (db) break;
        end
        check("b_latency", 64'(cyc), 64'd9);
        check("b_bcd", 64'(bcdb), m_bcd(v, 4));
        check("b_seg", 64'(segb), m_seg(v, 4, lz, 1'b0));
        check("b_ovf", 64'(ovb), 64'd0);
    endtask

    initial begin
        int dones;
        rst_n = 1'b0; va = 1'b0; ba = '0; lza = 1'b0; vb = 1'b0; bb = '0; lzbb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(ra), 64'd1);
        check("rst_done", 64'(da), 64'd0);
        check("rst_bcd", 64'(bcda), 64'd0);
        check("rst_ovf", 64'(ova), 64'd0);
        check("rst_seg", 64'(sega), 64'h3FF_FFFF_FFFF);
        check("rst_seg_b", 64'(segb), 64'd0);
        rst_n = 1'b1;

        run_a(123456, 1'b0, 1'b0);
        check("d0_six", 64'(sega[6:0]), 64'h02);
        check("d5_one", 64'(sega[41:35]), 64'h79);
        run_a(42, 1'b1, 1'b0);
        check("lzb_d1", 64'(sega[13:7]), 64'h19);
        check("lzb_d5", 64'(sega[41:35]), 64'h7F);
        run_a(0, 1'b1, 1'b0);
        check("zero_d0", 64'(sega[6:0]), 64'h40);
        run_a(999999, 1'b0, 1'b0);
        run_a(1000000, 1'b1, 1'b0);
        check("ovf_dash", 64'(sega[6:0]), 64'h3F);
        run_a(1048575, 1'b0, 1'b0);
        check("ovf_mod", 64'(bcda), 64'h048575);

        run_a(555, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("hold_done", 64'(da), 64'd0);
        check("hold_bcd", 64'(bcda), m_bcd(555, 6));

        repeat (10) run_a(longint'($urandom_range(0, 1048575)), 1'($urandom_range(0, 1)), 1'b0);

        // Abort mid-conversion; i_valid present on the reset edge must not start one.
        va = 1'b1; ba = 20'd654321; lza = 1'b0;
        @(posedge clk); #1;
        va = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0; va = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; va = 1'b0;
        check("abort_done", 64'(da), 64'd0);
        check("abort_bcd", 64'(bcda), 64'd0);
        check("abort_seg", 64'(sega), 64'h3FF_FFFF_FFFF);
        check("abort_ovf", 64'(ova), 64'd0);
        dones = 0;
        @(posedge clk); #1;
        check("abort_ready", 64'(ra), 64'd1);
        repeat (25) begin
            @(posedge clk); #1;
            if (da) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);

        run_b(255, 1'b1);
        check("b_d3_blank", 64'(segb[27:21]), 64'h00);
        check("b_d2", 64'(segb[20:14]), 64'h5B);
        repeat (6) run_b(longint'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
